sipo_deserializer: RTL and testbench

- Serial-in, parallel-out receiver. It is the far end of the team's right-shift PISO serializer, which sends LSB first.
- Collects N framed serial bits into one word, then presents the word on a valid/ready parallel interface.
- A one-word output holding register decouples the serial link from the consumer.
- Flags overrun (word lost) and resync (frame restarted mid-word).

---
 rtl/sipo_deserializer_if.sv | 38 +++
 rtl/sipo_deserializer.sv | 127 ++++++++++++
 tb/tb_sipo_deserializer.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/sipo_deserializer_if.sv
// ---------------------------------------------------------------------------
// sipo_deserializer_if
//   Bundles the serial link and the parallel valid/ready side of the
//   SIPO deserializer.
//   Parameters : N  - word width, CW - bit counter width
//   Signals    : serial_in, sin_valid, frame_start  (serial link, to receiver)
//                data_out, data_valid, data_ready   (parallel word handshake)
//                overrun, overrun_clr               (sticky drop flag / clear)
//                resync, busy, bit_count            (status)
//   Modports   : slave  - the deserializer itself
//                master - the environment (serializer + consumer)
// ---------------------------------------------------------------------------
interface sipo_deserializer_if #(
  parameter int N  = 4,
  parameter int CW = $clog2(N)
) ();
  logic          serial_in;
  logic          sin_valid;
  logic          frame_start;
  logic [N-1:0]  data_out;
  logic          data_valid;
  logic          data_ready;
  logic          overrun;
  logic          overrun_clr;
  logic          resync;
  logic          busy;
  logic [CW-1:0] bit_count;

  modport slave (
    input  serial_in, sin_valid, frame_start, data_ready, overrun_clr,
    output data_out, data_valid, overrun, resync, busy, bit_count
  );

  modport master (
    output serial_in, sin_valid, frame_start, data_ready, overrun_clr,
    input  data_out, data_valid, overrun, resync, busy, bit_count
  );
endinterface

// File: rtl/sipo_deserializer.sv
// ---------------------------------------------------------------------------
// sipo_deserializer
//   Serial-in, parallel-out receiver for an LSB-first framed bit stream.
//   Collects N bits into a word and offers it on a valid/ready interface
//   through a one-word holding register.
//   Ports:
//     clk  - clock, rising edge
//     rst  - synchronous active-high reset
//     bus  - sipo_deserializer_if.slave (serial link, word handshake, status)
// ---------------------------------------------------------------------------
module sipo_deserializer #(
  parameter int N  = 4,
  parameter int CW = $clog2(N)
) (
  input  logic                      clk,
  input  logic                      rst,
  sipo_deserializer_if.slave        bus
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t        state_q,  state_d;
  logic [N-1:0]  sreg_q,   sreg_d;
  logic [CW-1:0] cnt_q,    cnt_d;
  logic [N-1:0]  dout_q,   dout_d;
  logic          dvalid_q, dvalid_d;
  logic          ovr_q,    ovr_d;
  logic          resync_q, resync_d;

  // Shift register contents after accepting the current bit; on the Nth bit
  // this is also the completed word.
  logic [N-1:0]  word;
  logic          complete;
  logic          ovr_set;

  assign word = {bus.serial_in, sreg_q[N-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      sreg_q   <= '0;
      cnt_q    <= '0;
      dout_q   <= '0;
      dvalid_q <= 1'b0;
      ovr_q    <= 1'b0;
      resync_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sreg_q   <= sreg_d;
      cnt_q    <= cnt_d;
      dout_q   <= dout_d;
      dvalid_q <= dvalid_d;
      ovr_q    <= ovr_d;
      resync_q <= resync_d;
    end
  end

  // Frame FSM: bit capture and word completion.
  always_comb begin
    state_d  = state_q;
    sreg_d   = sreg_q;
    cnt_d    = cnt_q;
    resync_d = 1'b0;
    complete = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.sin_valid && bus.frame_start) begin
          sreg_d  = word;
          cnt_d   = CW'(1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (bus.sin_valid) begin
          sreg_d = word;
          if (bus.frame_start) begin
            // Restart takes priority even over what would be the Nth bit.
            // Stale bits left in sreg are shifted out before completion.
            resync_d = 1'b1;
            cnt_d    = CW'(1);
          end else if (cnt_q == CW'(N - 1)) begin
            complete = 1'b1;
            cnt_d    = '0;
            state_d  = IDLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output holding register and overrun flag.
  always_comb begin
    dout_d   = dout_q;
    dvalid_d = dvalid_q;
    ovr_set  = 1'b0;
    if (complete) begin
      // Load when empty, or when the held word leaves on this same edge.
      if (!dvalid_q || bus.data_ready) begin
        dout_d   = word;
        dvalid_d = 1'b1;
      end else begin
        ovr_set = 1'b1;
      end
    end else if (dvalid_q && bus.data_ready) begin
      dvalid_d = 1'b0;
    end
    // A new drop outranks a simultaneous clear.
    if (ovr_set) begin
      ovr_d = 1'b1;
    end else if (bus.overrun_clr) begin
      ovr_d = 1'b0;
    end else begin
      ovr_d = ovr_q;
    end
  end

  assign bus.data_out   = dout_q;
  assign bus.data_valid = dvalid_q;
  assign bus.overrun    = ovr_q;
  assign bus.resync     = resync_q;
  assign bus.busy       = (state_q == SHIFT);
  assign bus.bit_count  = cnt_q;

endmodule

// File: tb/tb_sipo_deserializer.sv
// ---------------------------------------------------------------------------
// tb_sipo_deserializer
//   Directed bench for sipo_deserializer with N=4. Expected words are queued
//   as the last bit of each frame is driven and checked whenever the DUT
//   hands a word over (data_valid && data_ready at a clock edge).
// ---------------------------------------------------------------------------
module tb_sipo_deserializer;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sipo_deserializer_if #(.N(N)) bus ();

  sipo_deserializer #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int compared   = 0;
  int mismatched = 0;
  logic [N-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock. A handshake seen just before the edge pops the
  // scoreboard and compares the word being consumed.
  task automatic tick();
    logic [N-1:0] e;
    if (!rst && bus.data_valid === 1'b1 && bus.data_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_word", 32'(bus.data_out), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("sb_word", 32'(bus.data_out), 32'(e));
      end
    end
    @(posedge clk);
    #1;
    $display("t=%0t sin_v=%0b bit=%0b fs=%0b rdy=%0b | dv=%0b dout=%0h ovr=%0b rsy=%0b busy=%0b cnt=%0d",
             $time, bus.sin_valid, bus.serial_in, bus.frame_start, bus.data_ready,
             bus.data_valid, bus.data_out, bus.overrun, bus.resync, bus.busy, bus.bit_count);
  endtask

  task automatic send_bit(input logic b, input logic fs);
    bus.sin_valid   = 1'b1;
    bus.serial_in   = b;
    bus.frame_start = fs;
    tick();
    bus.sin_valid   = 1'b0;
    bus.frame_start = 1'b0;
    bus.serial_in   = 1'b0;
  endtask

  // Sends a full LSB-first word; push selects whether it should reach the consumer.
  task automatic send_word(input logic [N-1:0] w, input bit push);
    for (int i = 0; i < N; i++) begin
      if (i == N - 1 && push) exp_q.push_back(w);
      send_bit(w[i], i == 0);
    end
  endtask

  initial begin
    rst             = 1'b1;
    bus.serial_in   = 1'b0;
    bus.sin_valid   = 1'b0;
    bus.frame_start = 1'b0;
    bus.data_ready  = 1'b0;
    bus.overrun_clr = 1'b0;
    #1;
    tick();
    tick();
    rst = 1'b0;
    check("rst_data_out",   32'(bus.data_out),   32'h0);
    check("rst_data_valid", 32'(bus.data_valid), 32'h0);
    check("rst_overrun",    32'(bus.overrun),    32'h0);
    check("rst_resync",     32'(bus.resync),     32'h0);
    check("rst_busy",       32'(bus.busy),       32'h0);
    check("rst_bit_count",  32'(bus.bit_count),  32'h0);

    // 1: single word 4'hD, bits 1,0,1,1 back to back
    bus.data_ready = 1'b1;
    send_bit(1'b1, 1'b1);
    check("t1_busy1", 32'(bus.busy), 32'h1);
    check("t1_cnt1",  32'(bus.bit_count), 32'd1);
    send_bit(1'b0, 1'b0);
    check("t1_cnt2",  32'(bus.bit_count), 32'd2);
    send_bit(1'b1, 1'b0);
    check("t1_cnt3",  32'(bus.bit_count), 32'd3);
    check("t1_busy3", 32'(bus.busy), 32'h1);
    check("t1_dv_early", 32'(bus.data_valid), 32'h0);
    exp_q.push_back(4'hD);
    send_bit(1'b1, 1'b0);
    check("t1_dv",   32'(bus.data_valid), 32'h1);
    check("t1_dout", 32'(bus.data_out),   32'hD);
    check("t1_cnt0", 32'(bus.bit_count),  32'd0);
    check("t1_busy0", 32'(bus.busy), 32'h0);
    tick();
    check("t1_dv_drop", 32'(bus.data_valid), 32'h0);
    check("t1_dout_hold", 32'(bus.data_out), 32'hD);

    // 2: same word with two idle cycles between bits
    for (int i = 0; i < N; i++) begin
      if (i == N - 1) exp_q.push_back(4'hD);
      send_bit(4'hD >> i, i == 0);
      if (i < N - 1) begin
        tick();
        tick();
        check("t2_cnt_hold", 32'(bus.bit_count), 32'(i + 1));
      end
    end
    check("t2_dv",   32'(bus.data_valid), 32'h1);
    check("t2_dout", 32'(bus.data_out),   32'hD);
    tick();
    check("t2_dv_drop", 32'(bus.data_valid), 32'h0);

    // 3: backpressure, second word dropped
    bus.data_ready = 1'b0;
    send_word(4'hA, 1'b1);
    send_word(4'h3, 1'b0);
    check("t3_dout",    32'(bus.data_out),   32'hA);
    check("t3_dv",      32'(bus.data_valid), 32'h1);
    check("t3_overrun", 32'(bus.overrun),    32'h1);
    bus.data_ready = 1'b1;
    tick();
    bus.data_ready = 1'b0;
    check("t3_dv_drop",   32'(bus.data_valid), 32'h0);
    check("t3_ovr_stick", 32'(bus.overrun),    32'h1);
    bus.overrun_clr = 1'b1;
    tick();
    bus.overrun_clr = 1'b0;
    check("t3_ovr_clr", 32'(bus.overrun), 32'h0);

    // 4: completion and consumption on the same edge
    send_word(4'h5, 1'b1);
    check("t4_hold5", 32'(bus.data_out), 32'h5);
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    bus.data_ready = 1'b1;
    exp_q.push_back(4'h9);
    send_bit(1'b1, 1'b0);
    check("t4_dout", 32'(bus.data_out),   32'h9);
    check("t4_dv",   32'(bus.data_valid), 32'h1);
    check("t4_ovr",  32'(bus.overrun),    32'h0);
    tick();
    check("t4_dv_drop", 32'(bus.data_valid), 32'h0);

    // 5: resync discards a partial word
    send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b0);
    check("t5_resync_pre", 32'(bus.resync), 32'h0);
    send_bit(1'b0, 1'b1);
    check("t5_resync", 32'(bus.resync),    32'h1);
    check("t5_cnt1",   32'(bus.bit_count), 32'd1);
    send_bit(1'b0, 1'b0);
    check("t5_resync_drop", 32'(bus.resync), 32'h0);
    send_bit(1'b1, 1'b0);
    exp_q.push_back(4'h4);
    send_bit(1'b0, 1'b0);
    check("t5_dout", 32'(bus.data_out), 32'h4);
    tick();

    // 6: reset mid-frame with a held word and overrun set
    bus.data_ready = 1'b0;
    send_word(4'hF, 1'b0);
    send_word(4'h1, 1'b0);
    check("t6_pre_dout", 32'(bus.data_out), 32'hF);
    check("t6_pre_ovr",  32'(bus.overrun),  32'h1);
    send_bit(1'b0, 1'b1);
    send_bit(1'b1, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_dv",   32'(bus.data_valid), 32'h0);
    check("t6_dout", 32'(bus.data_out),   32'h0);
    check("t6_busy", 32'(bus.busy),       32'h0);
    check("t6_cnt",  32'(bus.bit_count),  32'd0);
    check("t6_ovr",  32'(bus.overrun),    32'h0);
    bus.data_ready = 1'b1;
    send_word(4'h6, 1'b1);
    check("t6_dout6", 32'(bus.data_out), 32'h6);
    tick();
    tick();
    check("sb_leftover", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
